fpu_mant_align_seq: RTL and testbench

//  Iterative alignment shifter on the FP adder's input side.
//  - Right-shifts the smaller operand's 24-bit mantissa by the exponent difference.
//  - Produces the 27-bit extended mantissa {mant[23:0], G, R, S}, which the

---
 rtl/fpu_mant_align_seq_pkg.sv | 16 +
 rtl/fpu_sticky_shr.sv | 21 ++
 rtl/fpu_mant_align_seq.sv | 99 +++++++++
 tb/tb_fpu_mant_align_seq.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fpu_mant_align_seq_pkg.sv
// Shared constants and state encoding for the FP adder's mantissa alignment stage.
package fpu_mant_align_seq_pkg;

  localparam int MANT_W  = 24;
  localparam int EXT_W   = MANT_W + 3;
  localparam int SHAMT_W = 8;
  localparam int STEP    = 8;
  localparam int K_W     = $clog2(STEP + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/fpu_sticky_shr.sv
// Single variable right shift of 0..STEP bits; every bit shifted out is ORed into bit 0.
module fpu_sticky_shr #(
  parameter int EXT_W = 27,
  parameter int STEP  = 8,
  localparam int K_W  = $clog2(STEP + 1)
) (
  input  logic [EXT_W-1:0] din,
  input  logic [K_W-1:0]   k,
  output logic [EXT_W-1:0] dout
);

  logic [EXT_W-1:0] lost_mask;

  // Shift, then fold the discarded low bits into the sticky position
  always_comb begin
    lost_mask = ~({EXT_W{1'b1}} << k);
    dout      = din >> k;
    dout[0]   = dout[0] | (|(din & lost_mask));
  end

endmodule

// File: rtl/fpu_mant_align_seq.sv
// Iterative alignment shifter: right-shifts a mantissa by the exponent
// difference, at most STEP bits per cycle, producing {mant, G, R, S}.
module fpu_mant_align_seq
  import fpu_mant_align_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MANT_W-1:0]  in_mant,
  input  logic [SHAMT_W-1:0] in_shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [EXT_W-1:0]   out_mant_ext,
  output logic               busy
);

  state_e             state_q, state_d;
  logic [EXT_W-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic [K_W-1:0]     k;
  logic [SHAMT_W-1:0] rem_next;
  logic [EXT_W-1:0]   shr_out;

  // This cycle's shift amount is the remaining distance, capped at STEP
  always_comb begin
    k        = (rem_q < SHAMT_W'(STEP)) ? rem_q[K_W-1:0] : K_W'(STEP);
    rem_next = rem_q - SHAMT_W'(k);
  end

  fpu_sticky_shr #(
    .EXT_W (EXT_W),
    .STEP  (STEP)
  ) u_shr (
    .din  (acc_q),
    .k    (k),
    .dout (shr_out)
  );

  // Next-state logic: flush wins over accept and over the output handshake
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            acc_d = {in_mant, 3'b000};
            if (in_shamt >= SHAMT_W'(EXT_W)) begin
              acc_d   = {{(EXT_W-1){1'b0}}, |in_mant};
              state_d = DONE;
            end else if (in_shamt == '0) begin
              state_d = DONE;
            end else begin
              rem_d   = in_shamt;
              state_d = SHIFT;
            end
          end
        end
        SHIFT: begin
          acc_d = shr_out;
          rem_d = rem_next;
          if (rem_next == '0) begin
            state_d = DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, accumulator and remaining-shift registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign busy         = (state_q != IDLE);
  assign out_mant_ext = acc_q;

endmodule

// File: tb/tb_fpu_mant_align_seq.sv
// Self-checking bench for the iterative mantissa alignment shifter.
module tb_fpu_mant_align_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_mant = '0;
  logic [7:0]  in_shamt = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [26:0] out_mant_ext;
  logic        busy;

  int errors = 0;
  int checks = 0;

  // Free-running clock, period 10
  always #5 clk = ~clk;

  fpu_mant_align_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_mant      (in_mant),
    .in_shamt     (in_shamt),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_mant_ext (out_mant_ext),
    .busy         (busy)
  );

  // Reference: value*8 divided by 2^shamt, any nonzero remainder sets sticky
  function automatic logic [26:0] refAlign(input logic [23:0] m, input logic [7:0] s);
    longint v;
    longint p;
    longint r;
    if (s >= 8'd27) return {26'b0, (m != 24'd0)};
    v = longint'(m) * 8;
    p = longint'(1) << s;
    r = v / p;
    if ((v % p) != 0) r = r | 1;
    return r[26:0];
  endfunction

  // Reference: number of shift cycles between accept and result
  function automatic int refShifts(input logic [7:0] s);
    if (s == 8'd0 || s >= 8'd27) return 0;
    return (int'(s) + 7) / 8;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one operand, then count edges until out_valid while driving junk inputs
  task automatic applyStimulus(input logic [23:0] m, input logic [7:0] s, output int shifts);
    @(negedge clk);
    checkOutput("in_ready_idle", 32'(in_ready), 32'd1);
    in_mant  = m;
    in_shamt = s;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    shifts   = 0;
    in_mant  = 24'($urandom);
    in_shamt = 8'($urandom);
    while (out_valid !== 1'b1 && shifts < 12) begin
      @(posedge clk);
      #1;
      shifts++;
      in_mant  = 24'($urandom);
      in_shamt = 8'($urandom);
    end
    in_valid = 1'b0;
  endtask

  // Hold out_ready low for a while, then complete the output handshake
  task automatic drainOutput(input string tag, input int stall, input logic [26:0] exp);
    repeat (stall) begin
      @(posedge clk);
      #1;
      checkOutput({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
      checkOutput({tag, "_stall_data"}, 32'(out_mant_ext), 32'(exp));
      checkOutput({tag, "_stall_in_ready"}, 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput({tag, "_post_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
    checkOutput({tag, "_post_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic runOp(input string tag, input logic [23:0] m, input logic [7:0] s, input int stall);
    int shifts;
    logic [26:0] exp;
    exp = refAlign(m, s);
    applyStimulus(m, s, shifts);
    checkOutput({tag, "_latency"}, 32'(shifts), 32'(refShifts(s)));
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_data"}, 32'(out_mant_ext), 32'(exp));
    drainOutput(tag, stall, exp);
  endtask

  // Global watchdog so the run can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [23:0] m;
    logic [7:0]  s;

    // Reset values, including in_ready while rst_n is low
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_data", 32'(out_mant_ext), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    runOp("hidden_s0", 24'h800000, 8'd0, 0);
    runOp("ones_s3", 24'hFFFFFF, 8'd3, 0);
    runOp("lsb_s20", 24'h800001, 8'd20, 0);
    runOp("big_s200", 24'h000001, 8'd200, 0);
    runOp("zero_s200", 24'h000000, 8'd200, 0);
    runOp("max_s26", 24'hABCDEF, 8'd26, 0);
    runOp("edge_s27", 24'h800000, 8'd27, 0);
    runOp("edge_s8", 24'h123457, 8'd8, 0);
    runOp("zero_s13", 24'h000000, 8'd13, 0);
    runOp("stall5", 24'hC00003, 8'd5, 5);

    // Asynchronous reset in the middle of a shift
    @(negedge clk);
    in_mant = 24'hFFFFFF; in_shamt = 8'd26; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_mid_busy_before", 32'(busy), 32'd1);
    #2; rst_n = 1'b0; #1;
    checkOutput("rst_mid_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_mid_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_mid_busy", 32'(busy), 32'd0);
    checkOutput("rst_mid_data", 32'(out_mant_ext), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    runOp("after_rst", 24'h800001, 8'd20, 0);

    // Flush in the middle of a shift
    @(negedge clk);
    in_mant = 24'hFFFFFF; in_shamt = 8'd24; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    checkOutput("flush_mid_busy", 32'(busy), 32'd0);
    checkOutput("flush_mid_valid", 32'(out_valid), 32'd0);
    checkOutput("flush_mid_in_ready", 32'(in_ready), 32'd1);
    runOp("after_flush", 24'hFFFFFF, 8'd3, 0);

    // Flush in DONE beats the handshake; flush in IDLE beats an accept
    @(negedge clk);
    in_mant = 24'h800000; in_shamt = 8'd0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    checkOutput("flush_done_valid_before", 32'(out_valid), 32'd1);
    @(negedge clk); flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    checkOutput("flush_done_valid", 32'(out_valid), 32'd0);
    checkOutput("flush_done_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk); in_valid = 1'b1; in_mant = 24'h400000; in_shamt = 8'd0;
    @(posedge clk); #1; in_valid = 1'b0; flush = 1'b0;
    checkOutput("flush_idle_busy", 32'(busy), 32'd0);
    checkOutput("flush_idle_valid", 32'(out_valid), 32'd0);

    // Randomized operands against the arithmetic reference
    for (int i = 0; i < 60; i++) begin
      m = ($urandom_range(0, 7) == 0) ? 24'h0 : 24'($urandom);
      if ($urandom_range(0, 5) == 0) s = 8'($urandom_range(27, 255));
      else s = 8'($urandom_range(0, 30));
      runOp($sformatf("rnd%0d", i), m, s, int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
